// File: rtl/svm_dot_accum.sv
// Slice-VM decision stage: per-SV dot products, alpha scaling,
// frame sum plus bias, one signed decision and class bit per frame.
module svm_dot_accum #(
   parameter int VEC_LEN = 32,
   parameter int NUM_SV = 4,
   parameter int DOT_W = 24,
   parameter int DEC_W = 40,
   parameter logic signed [DEC_W-1:0] BIAS = '0,
   localparam int SW = (NUM_SV > 1) ? $clog2(NUM_SV) : 1,
   localparam int EW = $clog2(VEC_LEN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    dv,
   input  logic                    flush,
   input  logic signed [8:0]       feat_in,
   input  logic signed [8:0]       sv_in,
   input  logic signed [8:0]       svcoeff,
   output logic signed [DEC_W-1:0] decision,
   output logic                    class_out,
   output logic                    result_valid,
   output logic                    busy,
   output logic [SW-1:0]           sv_idx
);

   localparam int PW = DOT_W + 9;

   logic [EW-1:0]           elem_cnt;
   logic [SW-1:0]           sv_cnt;
   logic signed [DOT_W-1:0] dot_acc;
   logic signed [DOT_W-1:0] dot_q;
   logic signed [8:0]       coeff_q;
   logic                    scale_pend;
   logic                    last_sv;
   logic                    out_pend;
   logic signed [DEC_W-1:0] dec_acc;
   logic signed [DEC_W-1:0] decision_next;
   logic signed [17:0]      prod;
   logic signed [PW-1:0]    scaled;
   logic                    last_elem;
   logic                    last_vec;

   always_comb begin
      prod          = 18'(feat_in) * 18'(sv_in);
      scaled        = PW'(dot_q) * PW'(coeff_q);
      decision_next = dec_acc + BIAS;
      last_elem     = (elem_cnt == EW'(VEC_LEN - 1));
      last_vec      = (sv_cnt == SW'(NUM_SV - 1));
   end

   assign busy   = (elem_cnt != '0) | (sv_cnt != '0) | scale_pend | out_pend;
   assign sv_idx = sv_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         elem_cnt     <= '0;
         sv_cnt       <= '0;
         dot_acc      <= '0;
         dot_q        <= '0;
         coeff_q      <= '0;
         scale_pend   <= 1'b0;
         last_sv      <= 1'b0;
         out_pend     <= 1'b0;
         dec_acc      <= '0;
         decision     <= '0;
         class_out    <= 1'b0;
         result_valid <= 1'b0;
      end else if (flush) begin
         // Drop the partial frame and anything still in flight.
         elem_cnt     <= '0;
         sv_cnt       <= '0;
         dot_acc      <= '0;
         scale_pend   <= 1'b0;
         last_sv      <= 1'b0;
         out_pend     <= 1'b0;
         dec_acc      <= '0;
         result_valid <= 1'b0;
      end else begin
         scale_pend   <= 1'b0;
         out_pend     <= 1'b0;
         result_valid <= 1'b0;
         if (dv) begin
            if (last_elem) begin
               dot_q      <= dot_acc + DOT_W'(prod);
               coeff_q    <= svcoeff;
               scale_pend <= 1'b1;
               last_sv    <= last_vec;
               dot_acc    <= '0;
               elem_cnt   <= '0;
               sv_cnt     <= last_vec ? '0 : sv_cnt + SW'(1);
            end else begin
               dot_acc  <= dot_acc + DOT_W'(prod);
               elem_cnt <= elem_cnt + EW'(1);
            end
         end
         if (scale_pend) begin
            dec_acc  <= dec_acc + DEC_W'(scaled);
            out_pend <= last_sv;
         end
         // Never coincides with a scale since vectors span >= 2 beats.
         if (out_pend) begin
            decision     <= decision_next;
            class_out    <= ~decision_next[DEC_W-1];
            result_valid <= 1'b1;
            dec_acc      <= '0;
         end
      end
   end

endmodule

// File: tb/tb_svm_dot_accum.sv
// Scoreboard bench for svm_dot_accum with a frame-level
// reference model (VEC_LEN=4, NUM_SV=2, BIAS=0).
module tb_svm_dot_accum;

   localparam int VL = 4;
   localparam int NS = 2;
   localparam int FR = VL * NS;
   localparam int CW = 40;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 dv;
   logic                 flush;
   logic signed [8:0]    feat_in;
   logic signed [8:0]    sv_in;
   logic signed [8:0]    svcoeff;
   logic signed [CW-1:0] decision;
   logic                 class_out;
   logic                 result_valid;
   logic                 busy;
   logic [0:0]           sv_idx;

   svm_dot_accum #(
      .VEC_LEN(VL),
      .NUM_SV (NS),
      .DOT_W  (24),
      .DEC_W  (CW),
      .BIAS   (40'sd0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .dv          (dv),
      .flush       (flush),
      .feat_in     (feat_in),
      .sv_in       (sv_in),
      .svcoeff     (svcoeff),
      .decision    (decision),
      .class_out   (class_out),
      .result_valid(result_valid),
      .busy        (busy),
      .sv_idx      (sv_idx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint dec;
      bit     cls;
      int     at;
   } exp_t;

   exp_t sb[$];
   int   bf[$];
   int   bs[$];
   int   ba[$];
   int   pend_until = -1;
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic void kill(input int from);
      while (sb.size() > 0 && sb[$].at >= from) void'(sb.pop_back());
      pend_until = -1;
      bf.delete();
      bs.delete();
      ba.delete();
   endfunction

   // Reference: decision = sum_k alpha_k * sum_i feat*sv, alpha taken
   // from the last beat of each vector; result two edges later.
   task automatic step(input bit rs, input bit v, input int f,
                       input int s, input int a, input bit fl);
      longint tot;
      longint dot;
      reset   = rs;
      dv      = v;
      flush   = fl;
      feat_in = 9'(f);
      sv_in   = 9'(s);
      svcoeff = 9'(a);
      @(posedge clk);
      #1;
      if (rs || fl) begin
         kill(cyc);
      end else if (v) begin
         bf.push_back(f);
         bs.push_back(s);
         ba.push_back(a);
         if (bf.size() == FR) begin
            tot = 0;
            for (int k = 0; k < NS; k++) begin
               dot = 0;
               for (int i = 0; i < VL; i++)
                  dot += longint'(bf[k*VL+i]) * longint'(bs[k*VL+i]);
               tot += dot * longint'(ba[k*VL+VL-1]);
            end
            sb.push_back('{dec: tot, cls: (tot >= 0), at: cyc + 2});
            pend_until = cyc + 1;
            bf.delete();
            bs.delete();
            ba.delete();
         end
      end
      chk("sv_idx", longint'(sv_idx), longint'((bf.size() / VL) % NS));
      chk("busy", longint'(busy),
          longint'(bf.size() > 0 || cyc <= pend_until));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic beats(input int n, input int f, input int s, input int a);
      for (int i = 0; i < n; i++) step(0, 1, f, s, a, 0);
   endtask

   exp_t e;
   always @(negedge clk) begin
      if (result_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got decision %0d expected no pulse at cycle %0d",
                     $signed(decision), cyc);
         end else begin
            e = sb.pop_front();
            chk("decision", longint'($signed(decision)), e.dec);
            chk("class_out", longint'(class_out), longint'(e.cls));
            chk("latency", longint'(cyc), longint'(e.at));
         end
      end
   end

   initial begin
      reset   = 1'b1;
      dv      = 1'b0;
      flush   = 1'b0;
      feat_in = '0;
      sv_in   = '0;
      svcoeff = '0;
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 5, 5, 5, 0);
      chk("rst_decision", longint'($signed(decision)), 0);
      chk("rst_class", longint'(class_out), 0);
      chk("rst_valid", longint'(result_valid), 0);
      idle(2);

      // ones frame
      beats(FR, 1, 1, 1);
      idle(4);
      // signed extremes
      beats(FR, -256, -256, -1);
      idle(4);
      // alternating dv
      for (int i = 0; i < FR; i++) begin
         step(0, 1, 1, 1, 1, 0);
         step(0, 0, 7, 7, 7, 0);
      end
      idle(4);
      // reset mid-frame
      beats(3, 1, 1, 1);
      step(1, 0, 0, 0, 0, 0);
      beats(FR, 1, 1, 1);
      idle(4);
      // flush with dv on beat 5
      beats(4, 1, 1, 1);
      step(0, 1, 1, 1, 1, 1);
      beats(FR, 1, 1, 1);
      idle(4);
      // back-to-back frames
      beats(FR, 1, 1, 1);
      beats(FR, 2, 1, 1);
      idle(4);
      // flush killing an in-flight result
      beats(FR, 3, 3, 3);
      step(0, 0, 0, 0, 0, 1);
      idle(4);

      for (int i = 0; i < 600; i++) begin
         step(($urandom % 250) == 0,
              ($urandom % 10) < 7,
              int'($urandom_range(0, 511)) - 256,
              int'($urandom_range(0, 511)) - 256,
              int'($urandom_range(0, 511)) - 256,
              ($urandom % 60) == 0);
      end
      idle(6);
      chk("drained", longint'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
